// File: rtl/stream_rr_arbiter.sv
// Round-robin, packet-atomic merge of NUM_IN valid/ready streams into one
// registered output stream; a packet keeps the grant until its in_last beat.
module stream_rr_arbiter #(
    parameter  int NUM_IN = 4,
    parameter  int DATA_W = 8,
    localparam int SRC_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN-1:0]        in_last,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SRC_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready
);

    typedef enum logic {IDLE, LOCK} state_e;

    state_e            state_q, state_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [SRC_W-1:0]  owner_q, owner_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic              out_valid_q, out_valid_d;

    logic [SRC_W-1:0]  chosen, grant_idx;
    logic              found, grant_en, can_load, accept;
    logic              sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] i);
        return (i == SRC_W'(NUM_IN - 1)) ? '0 : i + 1'b1;
    endfunction

    // Search starts at ptr_q and wraps at NUM_IN, so non-power-of-two counts work.
    always_comb begin
        chosen = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            int unsigned idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_IN) idx = idx - NUM_IN;
            if (!found && in_valid[SRC_W'(idx)]) begin
                chosen = SRC_W'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        can_load  = !out_valid_q || out_ready;
        grant_en  = (state_q == LOCK) || found;
        grant_idx = (state_q == LOCK) ? owner_q : chosen;

        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        in_ready  = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (SRC_W'(k) == grant_idx) begin
                sel_valid   = in_valid[k];
                sel_last    = in_last[k];
                sel_data    = in_data[k*DATA_W +: DATA_W];
                in_ready[k] = grant_en && can_load && !rst;
            end
        end
        accept = grant_en && can_load && sel_valid && !rst;

        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = grant_idx;
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = wrap_inc(grant_idx);
            end else begin
                state_d = LOCK;
                owner_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed-vector bench for stream_rr_arbiter with hand-computed expectations.
module tb_stream_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d [4];
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last, in_ready;
    logic [7:0]  out_data;
    logic        out_last, out_valid, out_ready;
    logic [1:0]  out_src;

    int n_checks = 0;
    int n_pass   = 0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    stream_rr_arbiter #(.NUM_IN(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic beat(input int i, input logic [7:0] v, input logic l);
        d[i]       = v;
        in_last[i] = l;
    endtask

    task automatic check_out(input string tag, input logic [7:0] v, input logic l, input logic [1:0] s);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(v));
        check({tag, "_last"},  32'(out_last),  32'(l));
        check({tag, "_src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = '0;

        // 1. Reset
        step();
        check("rst_ready_during", 32'(in_ready), 32'h0);
        step();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_last",  32'(out_last),  32'h0);
        check("rst_out_src",   32'(out_src),   32'h0);
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(in_ready), 32'h0);
        step();
        check("post_rst_valid", 32'(out_valid), 32'h0);

        // 2. Single beat
        beat(0, 8'hfe, 1'b1);
        in_valid = 4'b0001;
        #1 check("single_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = '0;
        check_out("single", 8'hfe, 1'b1, 2'd0);

        // 3. Round-robin from ptr=0
        do_reset();
        for (int i = 0; i < 4; i++) beat(i, 8'h10 + 8'(i), 1'b1);
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_ready", 32'(in_ready), 32'h1 << (k % 4));
            step();
            check_out("rr", 8'h10 + 8'(k % 4), 1'b1, 2'(k % 4));
        end
        in_valid = '0;

        // 4. Packet lock with ptr=1
        do_reset();
        beat(0, 8'h00, 1'b1);
        in_valid = 4'b0001;
        step();
        beat(1, 8'ha1, 1'b0);
        beat(2, 8'hb0, 1'b1);
        in_valid = 4'b0110;
        #1 check("lock_a1_ready", 32'(in_ready), 32'h2);
        step();
        check_out("lock_a1", 8'ha1, 1'b0, 2'd1);
        beat(1, 8'ha2, 1'b0);
        #1 check("lock_a2_ready", 32'(in_ready), 32'h2);
        step();
        check_out("lock_a2", 8'ha2, 1'b0, 2'd1);
        in_valid = 4'b0100;
        #1 check("lock_bubble_ready", 32'(in_ready), 32'h2);
        step();
        check("lock_bubble_valid", 32'(out_valid), 32'h0);
        beat(1, 8'ha3, 1'b1);
        in_valid = 4'b0110;
        #1 check("lock_a3_ready", 32'(in_ready), 32'h2);
        step();
        check_out("lock_a3", 8'ha3, 1'b1, 2'd1);
        in_valid = 4'b0100;
        #1 check("lock_b0_ready", 32'(in_ready), 32'h4);
        step();
        in_valid = '0;
        check_out("lock_b0", 8'hb0, 1'b1, 2'd2);

        // 5. Backpressure
        do_reset();
        out_ready = 1'b0;
        beat(0, 8'h01, 1'b1);
        in_valid = 4'b0001;
        #1 check("bp_first_ready", 32'(in_ready), 32'h1);
        step();
        beat(0, 8'h02, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_stall_ready", 32'(in_ready), 32'h0);
            check_out("bp_stall", 8'h01, 1'b1, 2'd0);
            step();
        end
        out_ready = 1'b1;
        for (int v = 2; v <= 8; v++) begin
            beat(0, 8'(v), 1'b1);
            #1 check("bp_run_ready", 32'(in_ready), 32'h1);
            step();
            check_out("bp_run", 8'(v), 1'b1, 2'd0);
        end
        in_valid = '0;
        step();
        check("bp_drained", 32'(out_valid), 32'h0);

        // 6. Reset mid-packet
        do_reset();
        beat(0, 8'h00, 1'b1);
        in_valid = 4'b0001;
        step();
        beat(3, 8'hc1, 1'b0);
        in_valid = 4'b1000;
        step();
        check_out("mid_c1", 8'hc1, 1'b0, 2'd3);
        in_valid = '0;
        rst = 1'b1;
        #1 check("mid_rst_ready", 32'(in_ready), 32'h0);
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        beat(0, 8'h55, 1'b1);
        beat(3, 8'hc2, 1'b1);
        in_valid = 4'b1001;
        #1 check("mid_after_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = '0;
        check_out("mid_after", 8'h55, 1'b1, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
